// File: rtl/servo_pwm_bank_if.sv
// Configuration write port for servo_pwm_bank: valid/ready handshake plus
// a one-cycle error pulse for writes that address a channel that does not exist.
interface servo_pwm_bank_if #(
    parameter int CW = 1,
    parameter int W  = 20
) ();
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_ch;
    logic [W-1:0]  cfg_width;
    logic          cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_width,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_width,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM generator sharing one frame period; per-channel targets are
// clamped on write and slew-limited at frame boundaries so pulses never change mid-frame.
module servo_pwm_bank #(
    parameter int CH         = 2,
    parameter int PERIOD_CYC = 1_000_000,
    parameter int MIN_W      = 48_611,
    parameter int MAX_W      = 104_166,
    parameter int DEF_W      = 62_500,
    parameter int STEP       = 0,
    parameter int W          = $clog2(PERIOD_CYC),
    parameter int CW         = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    servo_pwm_bank_if.slave     cfg,
    input  logic [CH-1:0]       i_en,
    output logic [CH-1:0]       o_servo,
    output logic                o_frame_start,
    output logic [CH-1:0]       o_busy
);

    localparam logic [W-1:0] LP_LAST = W'(PERIOD_CYC - 1);
    localparam logic [W-1:0] LP_MIN  = W'(MIN_W);
    localparam logic [W-1:0] LP_MAX  = W'(MAX_W);
    localparam logic [W-1:0] LP_DEF  = W'(DEF_W);
    localparam logic [W:0]   LP_STEP = (W+1)'(STEP);

    logic [W-1:0]  r_cnt;
    logic [W-1:0]  r_tgt [CH];
    logic [W-1:0]  r_act [CH];
    logic [CH-1:0] r_en_f;
    logic          r_err;

    logic          w_boundary;
    logic          w_xfer;
    logic          w_ch_ok;
    logic [W-1:0]  w_clamped;
    logic [W-1:0]  w_act_nxt [CH];

    assign w_boundary    = (r_cnt == LP_LAST);
    assign cfg.cfg_ready = ~w_boundary;
    assign cfg.cfg_err   = r_err;
    assign w_xfer        = cfg.cfg_valid & ~w_boundary;
    assign w_ch_ok       = (32'(cfg.cfg_ch) < CH);

    always_comb begin
        w_clamped = cfg.cfg_width;
        if (cfg.cfg_width < LP_MIN) begin
            w_clamped = LP_MIN;
        end else if (cfg.cfg_width > LP_MAX) begin
            w_clamped = LP_MAX;
        end
    end

    // One extra bit on the slew arithmetic keeps act +/- STEP from wrapping.
    always_comb begin
        logic [W:0] v_diff;
        v_diff = '0;
        for (int i = 0; i < CH; i++) begin
            w_act_nxt[i] = r_tgt[i];
            if (STEP != 0) begin
                if (r_tgt[i] > r_act[i]) begin
                    v_diff = {1'b0, r_tgt[i]} - {1'b0, r_act[i]};
                    if (v_diff > LP_STEP) begin
                        w_act_nxt[i] = W'({1'b0, r_act[i]} + LP_STEP);
                    end
                end else begin
                    v_diff = {1'b0, r_act[i]} - {1'b0, r_tgt[i]};
                    if (v_diff > LP_STEP) begin
                        w_act_nxt[i] = W'({1'b0, r_act[i]} - LP_STEP);
                    end
                end
            end
        end
    end

    always_comb begin
        o_busy = '0;
        for (int i = 0; i < CH; i++) begin
            o_busy[i] = (r_act[i] != r_tgt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_boundary) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_xfer & ~w_ch_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_tgt[i] <= LP_DEF;
            end
        end else if (w_xfer && w_ch_ok) begin
            for (int i = 0; i < CH; i++) begin
                if (32'(cfg.cfg_ch) == i) begin
                    r_tgt[i] <= w_clamped;
                end
            end
        end
    end

    // act and the enable latch only move on the wrap edge so a frame is never reshaped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_act[i] <= LP_DEF;
            end
            r_en_f <= '0;
        end else if (w_boundary) begin
            for (int i = 0; i < CH; i++) begin
                r_act[i] <= w_act_nxt[i];
            end
            r_en_f <= i_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_servo       <= '0;
            o_frame_start <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                o_servo[i] <= r_en_f[i] & (r_cnt < r_act[i]);
            end
            o_frame_start <= (r_cnt == '0);
        end
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank: expected per-frame pulse widths are queued as
// stimulus is applied and compared against measured widths when each frame completes.
module tb_servo_pwm_bank;

    localparam int CH = 2;
    localparam int PERIOD = 1000;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] en;
    logic [CH-1:0] servo;
    logic          frame_start;
    logic [CH-1:0] busy;

    servo_pwm_bank_if #(.CW(2), .W(10)) cfg_if ();

    servo_pwm_bank #(
        .CH(CH), .PERIOD_CYC(PERIOD), .MIN_W(50), .MAX_W(200), .DEF_W(100),
        .STEP(20), .W(10), .CW(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg(cfg_if),
        .i_en(en),
        .o_servo(servo),
        .o_frame_start(frame_start),
        .o_busy(busy)
    );

    typedef struct {
        int w0;
        int w1;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   tb_cnt;
    int   tb_frame;
    int   hi0, hi1;
    bit   active;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, checks=%0d fails=%0d", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int a, input int b);
        exp_t e;
        e.w0 = a;
        e.w1 = b;
        q.push_back(e);
    endtask

    // Bench's own view of the frame timebase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_cnt   <= 0;
            tb_frame <= 0;
        end else if (tb_cnt == PERIOD - 1) begin
            tb_cnt   <= 0;
            tb_frame <= tb_frame + 1;
        end else begin
            tb_cnt <= tb_cnt + 1;
        end
    end

    always @(negedge rst_n) begin
        q.delete();
        active = 0;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (frame_start === 1'b1) begin
                if (active) begin
                    chk("queue_nonempty", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        exp_t e;
                        e = q.pop_front();
                        chk("width_ch0", hi0, e.w0);
                        chk("width_ch1", hi1, e.w1);
                    end
                end
                active = 1;
                hi0 = 0;
                hi1 = 0;
                if (q.size() != 0) begin
                    chk("rise_ch0", servo[0], q[0].w0 != 0);
                    chk("rise_ch1", servo[1], q[0].w1 != 0);
                end
            end
            if (active) begin
                hi0 += int'(servo[0]);
                hi1 += int'(servo[1]);
            end
        end
    end

    task automatic goto(input int f, input int c);
        int n = 0;
        while (!(tb_frame == f && tb_cnt == c) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("goto_reached", (tb_frame == f && tb_cnt == c), 1);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [9:0] wd);
        int n = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_width = wd;
        while (cfg_if.cfg_ready !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", cfg_if.cfg_ready, 1);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 2'b11;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_width = '0;
        repeat (3) @(negedge clk);
        chk("rst_servo", servo, 0);
        chk("rst_ready", cfg_if.cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_err", cfg_if.cfg_err, 0);

        push_exp(0, 0);
        push_exp(100, 100);
        push_exp(100, 100);
        rst_n = 1'b1;

        goto(1, 1);
        chk("frame_start_hi", frame_start, 1);
        goto(1, 2);
        chk("frame_start_lo", frame_start, 0);

        // Slew ch0 from 100 to 180 in steps of 20.
        goto(2, 300);
        push_exp(120, 100);
        push_exp(140, 100);
        push_exp(160, 100);
        push_exp(180, 100);
        push_exp(180, 100);
        cfg_write(2'd0, 10'd180);
        chk("busy_after_wr0", busy, 2'b01);
        goto(3, 500);
        chk("busy_f3", busy, 2'b01);
        goto(5, 500);
        chk("busy_f5", busy, 2'b01);
        goto(6, 500);
        chk("busy_f6", busy, 2'b00);

        // Clamp low on ch1.
        goto(7, 300);
        push_exp(180, 80);
        push_exp(180, 60);
        push_exp(180, 50);
        push_exp(180, 50);
        cfg_write(2'd1, 10'd10);
        chk("busy_after_wr1lo", busy, 2'b10);
        goto(10, 500);
        chk("busy_f10", busy, 2'b00);

        // Clamp high on ch1.
        goto(11, 300);
        push_exp(180, 70);
        push_exp(180, 90);
        push_exp(180, 110);
        push_exp(180, 130);
        push_exp(180, 150);
        push_exp(180, 170);
        push_exp(180, 190);
        push_exp(180, 200);
        push_exp(180, 200);
        cfg_write(2'd1, 10'd900);
        chk("busy_after_wr1hi", busy, 2'b10);
        goto(19, 500);
        chk("busy_f19", busy, 2'b00);

        // Write held across the boundary cycle transfers at cnt = 0.
        push_exp(180, 200);
        push_exp(170, 200);
        goto(20, 999);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_width = 10'd170;
        chk("ready_boundary", cfg_if.cfg_ready, 0);
        @(negedge clk);
        chk("ready_cnt0", cfg_if.cfg_ready, 1);
        chk("busy_cnt0_pending", busy, 2'b00);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("busy_cnt1_taken", busy, 2'b01);

        // Out-of-range channel.
        goto(22, 300);
        push_exp(170, 200);
        chk("err_idle", cfg_if.cfg_err, 0);
        cfg_write(2'd3, 10'd60);
        chk("err_pulse", cfg_if.cfg_err, 1);
        @(negedge clk);
        chk("err_one_cycle", cfg_if.cfg_err, 0);
        chk("err_no_change", busy, 2'b00);

        // Mid-frame disable of ch1.
        push_exp(170, 0);
        goto(23, 500);
        en = 2'b01;

        // Asynchronous reset during a ch0 pulse.
        goto(25, 40);
        chk("pre_reset_servo", servo, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_servo_drop", servo, 0);
        chk("reset_frame_start", frame_start, 0);
        chk("reset_ready", cfg_if.cfg_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_err", cfg_if.cfg_err, 0);
        en = 2'b11;
        repeat (2) @(negedge clk);
        push_exp(0, 0);
        push_exp(100, 100);
        push_exp(100, 100);
        rst_n = 1'b1;

        goto(3, 10);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
